rom_fetch_ctrl: RTL and testbench

Synchronous fetch sequencer between a requesting engine (CPU bus shim or video tile/sprite fetcher) and an asynchronous EPROM model. Accepts single-beat or short-burst read requests, drives the ROM address and active-low chip/output enables, and waits a fixed number of clocks to cover the EPROM access time. It then registers the ROM data and returns one response pulse per byte.

---
 rtl/rom_fetch_pkg.sv | 15 +
 rtl/rom_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_rom_fetch_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the EPROM fetch sequencer.
// Used by rom_fetch_ctrl; the optional read cache is enabled with ROM_FETCH_CACHE_EN.
package rom_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StCapture,
        StHit
    } fetch_state_e;

    localparam int unsigned LenWidth          = 4;
    localparam int unsigned DefaultWaitCycles = 4;

endpackage

// File: rtl/rom_fetch_ctrl.sv
// Fetch sequencer between a requesting engine and an asynchronous EPROM.
// Define ROM_FETCH_CACHE_EN to add a one-entry tag that serves repeated single-byte reads.
module rom_fetch_ctrl
    import rom_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned WAIT_CYCLES = DefaultWaitCycles
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [LenWidth-1:0]   REQ_LEN,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  RSP_LAST,
    output logic [ADDR_WIDTH-1:0] ROM_ADDR,
    output logic                  ROM_CEn,
    output logic                  ROM_OEn,
    input  logic [DATA_WIDTH-1:0] ROM_DATA
);

    localparam int unsigned CntWidth = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntWidth-1:0] WaitLoad = CntWidth'(WAIT_CYCLES - 1);

    fetch_state_e        state_q;
    logic [CntWidth-1:0] wait_q;
    logic [LenWidth-1:0] beats_q;
    logic                capture;

    // Last access cycle of a beat: ROM_DATA has settled and is sampled on this edge.
    assign capture = (state_q == StAccess) && (wait_q == '0);

`ifdef ROM_FETCH_CACHE_EN
    logic                  tag_valid_q;
    logic [ADDR_WIDTH-1:0] tag_addr_q;
    logic [DATA_WIDTH-1:0] tag_data_q;
    logic                  cache_hit;

    assign cache_hit = tag_valid_q && (tag_addr_q == REQ_ADDR) && (REQ_LEN == '0);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            tag_valid_q <= 1'b0;
            tag_addr_q  <= '0;
            tag_data_q  <= '0;
        end else if (capture) begin
            tag_valid_q <= 1'b1;
            tag_addr_q  <= ROM_ADDR;
            tag_data_q  <= ROM_DATA;
        end
    end
`endif

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            beats_q   <= '0;
            REQ_READY <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_LAST  <= 1'b0;
            RSP_DATA  <= '0;
            ROM_ADDR  <= '0;
            ROM_CEn   <= 1'b1;
            ROM_OEn   <= 1'b1;
        end else begin
            RSP_VALID <= 1'b0;
            RSP_LAST  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (REQ_VALID) begin
                        REQ_READY <= 1'b0;
`ifdef ROM_FETCH_CACHE_EN
                        if (cache_hit) begin
                            state_q   <= StHit;
                            RSP_VALID <= 1'b1;
                            RSP_LAST  <= 1'b1;
                            RSP_DATA  <= tag_data_q;
                        end else begin
`else
                        begin
`endif
                            state_q  <= StAccess;
                            ROM_ADDR <= REQ_ADDR;
                            ROM_CEn  <= 1'b0;
                            ROM_OEn  <= 1'b0;
                            wait_q   <= WaitLoad;
                            beats_q  <= REQ_LEN;
                        end
                    end
                end
                StAccess: begin
                    if (capture) begin
                        state_q   <= StCapture;
                        RSP_DATA  <= ROM_DATA;
                        RSP_VALID <= 1'b1;
                        RSP_LAST  <= (beats_q == '0);
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                StCapture: begin
                    if (beats_q != '0) begin
                        // Enables stay low between beats; only the address advances.
                        state_q  <= StAccess;
                        beats_q  <= beats_q - 1'b1;
                        ROM_ADDR <= ROM_ADDR + 1'b1;
                        wait_q   <= WaitLoad;
                    end else begin
                        state_q   <= StIdle;
                        REQ_READY <= 1'b1;
                        ROM_CEn   <= 1'b1;
                        ROM_OEn   <= 1'b1;
                    end
                end
`ifdef ROM_FETCH_CACHE_EN
                StHit: begin
                    state_q   <= StIdle;
                    REQ_READY <= 1'b1;
                end
`endif
                default: begin
                    state_q   <= StIdle;
                    REQ_READY <= 1'b1;
                    ROM_CEn   <= 1'b1;
                    ROM_OEn   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl: two instances (WAIT_CYCLES 4 and 1) against a schedule-based model.
// Cache checks are included when ROM_FETCH_CACHE_EN is defined.
module tb_rom_fetch_ctrl;

    localparam int AW = 15;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int H  = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    logic [DW-1:0] rom [1 << AW];

    logic          req_valid [2];
    logic [AW-1:0] req_addr  [2];
    logic [LW-1:0] req_len   [2];
    logic          req_ready [2];
    logic          rsp_valid [2];
    logic [DW-1:0] rsp_data  [2];
    logic          rsp_last  [2];
    logic [AW-1:0] rom_addr  [2];
    logic          rom_cen   [2];
    logic          rom_oen   [2];
    logic [DW-1:0] rom_data  [2];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input int g, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int W = (g == 0) ? 4 : 1;

        rom_fetch_ctrl #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .WAIT_CYCLES(W)
        ) u_dut (
            .clk      (clk),
            .RSTn     (rst_n),
            .REQ_VALID(req_valid[g]),
            .REQ_READY(req_ready[g]),
            .REQ_ADDR (req_addr[g]),
            .REQ_LEN  (req_len[g]),
            .RSP_VALID(rsp_valid[g]),
            .RSP_DATA (rsp_data[g]),
            .RSP_LAST (rsp_last[g]),
            .ROM_ADDR (rom_addr[g]),
            .ROM_CEn  (rom_cen[g]),
            .ROM_OEn  (rom_oen[g]),
            .ROM_DATA (rom_data[g])
        );

        assign rom_data[g] = rom[rom_addr[g]];

        // e_*[k]: expected outputs during the cycle following clock edge k.
        logic          e_valid [H];
        logic          e_last  [H];
        logic          e_cen   [H];
        logic          e_ready [H];
        logic [DW-1:0] e_data  [H];
        logic [AW-1:0] e_addr  [H];
        int            cyc = 0;
`ifdef ROM_FETCH_CACHE_EN
        logic          tag_v;
        logic [AW-1:0] tag_a;
        logic [DW-1:0] tag_d;
`endif

        initial begin
            int            c, nb, total, s;
            logic          hit;
            logic [AW-1:0] a, ad;
            logic [LW-1:0] l;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    for (int k = cyc; k < H; k++) begin
                        e_valid[k] = 1'b0;
                        e_last[k]  = 1'b0;
                        e_cen[k]   = 1'b1;
                        e_ready[k] = 1'b1;
                        e_data[k]  = '0;
                        e_addr[k]  = '0;
                    end
`ifdef ROM_FETCH_CACHE_EN
                    tag_v = 1'b0;
`endif
                end else if (cyc < H - 1) begin
                    cyc++;
                    if (e_ready[cyc-1] && req_valid[g]) begin
                        c   = cyc;
                        a   = req_addr[g];
                        l   = req_len[g];
                        hit = 1'b0;
`ifdef ROM_FETCH_CACHE_EN
                        hit = (l == '0) && tag_v && (tag_a == a);
`endif
                        if (hit) begin
`ifdef ROM_FETCH_CACHE_EN
                            e_valid[c] = 1'b1;
                            e_last[c]  = 1'b1;
                            e_data[c]  = tag_d;
                            e_ready[c] = 1'b0;
`endif
                        end else begin
                            nb    = int'(l) + 1;
                            total = nb * (W + 1);
                            for (int k = 0; k < total; k++) begin
                                if (c + k < H) begin
                                    e_ready[c+k] = 1'b0;
                                    e_cen[c+k]   = 1'b0;
                                    e_addr[c+k]  = a + AW'(k / (W + 1));
                                end
                            end
                            for (int n = 0; n < nb; n++) begin
                                s  = c + (n + 1) * W + n;
                                ad = a + AW'(n);
                                if (s < H) begin
                                    e_valid[s] = 1'b1;
                                    e_data[s]  = rom[ad];
                                    e_last[s]  = (n == nb - 1);
                                end
                            end
`ifdef ROM_FETCH_CACHE_EN
                            tag_v = 1'b1;
                            tag_a = a + AW'(nb - 1);
                            tag_d = rom[tag_a];
`endif
                        end
                    end
                end
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                check("req_ready", g, 32'(req_ready[g]), 32'(e_ready[cyc]));
                check("rom_cen", g, 32'(rom_cen[g]), 32'(e_cen[cyc]));
                check("rom_oen", g, 32'(rom_oen[g]), 32'(e_cen[cyc]));
                check("rsp_valid", g, 32'(rsp_valid[g]), 32'(e_valid[cyc]));
                if (e_valid[cyc]) begin
                    check("rsp_data", g, 32'(rsp_data[g]), 32'(e_data[cyc]));
                    check("rsp_last", g, 32'(rsp_last[g]), 32'(e_last[cyc]));
                end
                if (!e_cen[cyc]) check("rom_addr", g, 32'(rom_addr[g]), 32'(e_addr[cyc]));
            end
        end
    end

    // Directed observation results, written only by the stimulus process.
    int            ob_cen, ob_val, ob_last, ob_lastval_at, ob_lastflag_at, ob_naddr;
    logic [DW-1:0] ob_data [16];
    logic [AW-1:0] ob_addr [16];

    task automatic issue(input int g, input logic [AW-1:0] a, input logic [LW-1:0] l,
                         output int waited);
        waited = 0;
        @(negedge clk);
        req_valid[g] = 1'b1;
        req_addr[g]  = a;
        req_len[g]   = l;
        while (!req_ready[g] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready[g]) check("req_ready_timeout", g, 32'(req_ready[g]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[g] = 1'b0;
        req_addr[g]  = ~a;
        req_len[g]   = ~l;
    endtask

    task automatic observe(input int g, input int n);
        ob_cen = 0; ob_val = 0; ob_last = 0; ob_naddr = 0;
        ob_lastval_at = -1; ob_lastflag_at = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rom_cen[g]) begin
                ob_cen++;
                if (ob_naddr == 0 || ob_addr[(ob_naddr > 0) ? ob_naddr - 1 : 0] != rom_addr[g]) begin
                    if (ob_naddr < 16) ob_addr[ob_naddr] = rom_addr[g];
                    ob_naddr++;
                end
            end
            if (rsp_valid[g]) begin
                if (ob_val < 16) ob_data[ob_val] = rsp_data[g];
                ob_val++;
                if (rsp_last[g]) begin
                    ob_last++;
                    ob_lastflag_at = ob_val;
                end
                ob_lastval_at = i;
            end
        end
    endtask

    initial begin
        int            w;
        logic [AW-1:0] ad;
        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'((i * 7) + (i >> 8));
        rom[15'h1234] = 8'hA5;
        rom[15'h7FFE] = 8'h11;
        rom[15'h7FFF] = 8'h22;
        rom[15'h0000] = 8'h33;
        rom[15'h0001] = 8'h44;
        rom[15'h0100] = 8'h5A;
        rom[15'h0101] = 8'h6B;
        rom[15'h0300] = 8'hC3;
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0;
            req_addr[g]  = '0;
            req_len[g]   = '0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("reset_ready", 0, 32'(req_ready[0]), 32'd1);
        check("reset_cen", 0, 32'(rom_cen[0]), 32'd1);
        check("reset_valid", 0, 32'(rsp_valid[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single read.
        issue(0, 15'h1234, 4'd0, w);
        observe(0, 10);
        check("single_cen_cycles", 0, 32'(ob_cen), 32'd5);
        check("single_pulses", 0, 32'(ob_val), 32'd1);
        check("single_data", 0, 32'(ob_data[0]), 32'hA5);
        check("single_last", 0, 32'(ob_last), 32'd1);
        check("single_latency", 0, 32'(ob_lastval_at + 1), 32'd5);

        // Burst across the top of the address space.
        issue(0, 15'h7FFE, 4'd3, w);
        observe(0, 25);
        check("burst_naddr", 0, 32'(ob_naddr), 32'd4);
        check("burst_addr0", 0, 32'(ob_addr[0]), 32'h7FFE);
        check("burst_addr1", 0, 32'(ob_addr[1]), 32'h7FFF);
        check("burst_addr2", 0, 32'(ob_addr[2]), 32'h0000);
        check("burst_addr3", 0, 32'(ob_addr[3]), 32'h0001);
        check("burst_pulses", 0, 32'(ob_val), 32'd4);
        check("burst_last_pos", 0, 32'(ob_lastflag_at), 32'd4);
        check("burst_last_cnt", 0, 32'(ob_last), 32'd1);
        check("burst_cen_cycles", 0, 32'(ob_cen), 32'd20);
        check("burst_data0", 0, 32'(ob_data[0]), 32'h11);
        check("burst_data1", 0, 32'(ob_data[1]), 32'h22);
        check("burst_data2", 0, 32'(ob_data[2]), 32'h33);
        check("burst_data3", 0, 32'(ob_data[3]), 32'h44);

        // Request held while busy; accepted after the final capture.
        issue(0, 15'h0200, 4'd2, w);
        check("busy_ready", 0, 32'(req_ready[0]), 32'd0);
        issue(0, 15'h0300, 4'd0, w);
        check("busy_wait", 0, 32'(w), 32'd15);
        observe(0, 8);
        check("busy_new_addr", 0, 32'(ob_addr[0]), 32'h0300);
        check("busy_new_data", 0, 32'(ob_data[0]), 32'hC3);

        // Reset in the middle of beat 2 of an 8-beat burst.
        issue(0, 15'h0500, 4'd7, w);
        observe(0, 13);
        check("rst_pre_pulses", 0, 32'(ob_val), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", 0, 32'(req_ready[0]), 32'd1);
        check("rst_valid", 0, 32'(rsp_valid[0]), 32'd0);
        check("rst_last", 0, 32'(rsp_last[0]), 32'd0);
        check("rst_data", 0, 32'(rsp_data[0]), 32'd0);
        check("rst_addr", 0, 32'(rom_addr[0]), 32'd0);
        check("rst_cen", 0, 32'(rom_cen[0]), 32'd1);
        check("rst_oen", 0, 32'(rom_oen[0]), 32'd1);
        observe(0, 4);
        check("rst_no_pulse", 0, 32'(ob_val), 32'd0);
        rst_n = 1'b1;
        issue(0, 15'h1234, 4'd0, w);
        observe(0, 8);
        check("post_rst_data", 0, 32'(ob_data[0]), 32'hA5);
        check("post_rst_latency", 0, 32'(ob_lastval_at + 1), 32'd5);

        // WAIT_CYCLES=1, 16-beat burst.
        issue(1, 15'h0400, 4'd15, w);
        observe(1, 40);
        check("w1_pulses", 1, 32'(ob_val), 32'd16);
        check("w1_latency", 1, 32'(ob_lastval_at + 1), 32'd32);
        check("w1_last", 1, 32'(ob_last), 32'd1);
        check("w1_cen_cycles", 1, 32'(ob_cen), 32'd32);
        for (int i = 0; i < 16; i++) begin
            ad = 15'h0400 + AW'(i);
            check("w1_data", 1, 32'(ob_data[i]), 32'(rom[ad]));
        end

`ifdef ROM_FETCH_CACHE_EN
        issue(0, 15'h0100, 4'd0, w);
        observe(0, 8);
        check("cache_miss_data", 0, 32'(ob_data[0]), 32'h5A);
        issue(0, 15'h0100, 4'd0, w);
        observe(0, 8);
        check("cache_hit_latency", 0, 32'(ob_lastval_at), 32'd0);
        check("cache_hit_cen", 0, 32'(ob_cen), 32'd0);
        check("cache_hit_data", 0, 32'(ob_data[0]), 32'h5A);
        check("cache_hit_last", 0, 32'(ob_last), 32'd1);
        issue(0, 15'h0101, 4'd0, w);
        observe(0, 8);
        check("cache_next_cen", 0, 32'(ob_cen), 32'd5);
        check("cache_next_data", 0, 32'(ob_data[0]), 32'h6B);
`endif

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
